// File: rtl/range_counter.sv
// Programmable up/down range counter with wrap, saturate and one-shot end-of-range
// behaviour, an enable prescaler, clamped load, terminal-count pulse and done flag.
module range_counter #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_START = 0,
    parameter int unsigned COUNT_END   = 2**DATA_WIDTH-1,
    parameter int unsigned STEP        = 1,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] loadval,
    input  logic                  dir,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  tc,
    output logic                  done
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_e;

    typedef logic [DATA_WIDTH:0] wide_t;

    localparam int unsigned MAX_V = (DATA_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << DATA_WIDTH) - 32'd1);
    localparam int unsigned PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [DATA_WIDTH-1:0] START_V      = DATA_WIDTH'(COUNT_START);
    localparam logic [DATA_WIDTH-1:0] END_V        = DATA_WIDTH'(COUNT_END);
    localparam wide_t                 END_W        = wide_t'(COUNT_END);
    localparam wide_t                 STEP_W       = wide_t'(STEP);
    localparam wide_t                 START_STEP_W = wide_t'(COUNT_START + STEP);
    localparam logic [PW-1:0]         PRE_LAST     = PW'(PRESCALE - 1);

    if (COUNT_START >= COUNT_END || COUNT_END > MAX_V || STEP == 0 ||
        STEP > COUNT_END - COUNT_START || PRESCALE == 0) begin : gBadParams
        $error("range_counter: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  tc_q, tc_d;
    logic                  done_q, done_d;
    logic [PW-1:0]         pre_q, pre_d;

    logic                  tick;
    wide_t                 countW;
    wide_t                 upSum;
    wide_t                 downDiff;
    logic [DATA_WIDTH-1:0] tickVal;
    logic                  boundary;
    logic                  tickDone;
    logic                  tickTc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= START_V;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
        end
    end

    // Sums are one bit wider than the counter so crossing the top of the range is visible.
    always_comb begin
        tick     = en && (pre_q == PRE_LAST) && !done_q;
        countW   = {1'b0, count_q};
        upSum    = countW + STEP_W;
        downDiff = countW - STEP_W;
        tickVal  = count_q;
        boundary = 1'b0;
        tickDone = 1'b0;
        if (dir) begin
            if (upSum <= END_W) begin
                tickVal = DATA_WIDTH'(upSum);
            end else begin
                boundary = 1'b1;
                case (mode_e'(mode))
                    MODE_SAT:     tickVal = END_V;
                    MODE_ONESHOT: begin
                        tickVal  = END_V;
                        tickDone = 1'b1;
                    end
                    default:      tickVal = START_V;
                endcase
            end
        end else begin
            if (countW >= START_STEP_W) begin
                tickVal = DATA_WIDTH'(downDiff);
            end else begin
                boundary = 1'b1;
                case (mode_e'(mode))
                    MODE_SAT:     tickVal = START_V;
                    MODE_ONESHOT: begin
                        tickVal  = START_V;
                        tickDone = 1'b1;
                    end
                    default:      tickVal = END_V;
                endcase
            end
        end
        // A saturated counter already parked on its limit must not re-pulse.
        tickTc = boundary && ((mode_e'(mode) == MODE_WRAP) ||
                              (mode_e'(mode) == MODE_WRAP_ALT) ||
                              (tickVal != count_q));
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        pre_d   = pre_q;
        if (clr) begin
            count_d = START_V;
            done_d  = 1'b0;
            pre_d   = '0;
        end else if (load) begin
            if (loadval < START_V) begin
                count_d = START_V;
            end else if (loadval > END_V) begin
                count_d = END_V;
            end else begin
                count_d = loadval;
            end
            done_d = 1'b0;
            pre_d  = '0;
        end else begin
            if (en && !done_q) begin
                pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
            end
            if (tick) begin
                count_d = tickVal;
                tc_d    = tickTc;
                done_d  = done_q | tickDone;
            end
        end
    end

    assign dataOut = count_q;
    assign tc      = tc_q;
    assign done    = done_q;

endmodule

// File: tb/tb_range_counter.sv
// Scoreboard bench for range_counter (4-bit, range 2..12, step 3) plus a PRESCALE=3 instance.
module tb_range_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       en3;
    logic       clr;
    logic       load;
    logic [3:0] loadval;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] dataOut;
    logic       tc;
    logic       done;
    logic [3:0] dataOut3;
    logic       tc3;
    logic       done3;

    logic [5:0] expQ[$];
    logic [5:0] expV;
    logic [5:0] gotV;
    int         nChecks = 0;
    int         nFail   = 0;
    int         n;

    always #5 clk = ~clk;

    range_counter #(.DATA_WIDTH(4), .COUNT_START(2), .COUNT_END(12), .STEP(3), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .loadval(loadval),
        .dir(dir), .mode(mode), .dataOut(dataOut), .tc(tc), .done(done)
    );

    range_counter #(.DATA_WIDTH(4), .COUNT_START(2), .COUNT_END(12), .STEP(3), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .clr(clr), .load(load), .loadval(loadval),
        .dir(dir), .mode(mode), .dataOut(dataOut3), .tc(tc3), .done(done3)
    );

    // Expected-value vector layout: {tc, done, dataOut}.
    function automatic logic [5:0] ev(input int d, input logic t, input logic dn);
        return {t, dn, 4'(d)};
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; en3 = 1'b0; clr = 1'b0; load = 1'b0;
        loadval = 4'd0; dir = 1'b1; mode = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if (dataOut !== 4'd2) begin nFail++; $display("FAIL reset_data: dataOut=%0d expected 2", dataOut); end
        nChecks++;
        if (tc !== 1'b0) begin nFail++; $display("FAIL reset_tc: tc=%b expected 0", tc); end
        nChecks++;
        if (done !== 1'b0) begin nFail++; $display("FAIL reset_done: done=%b expected 0", done); end
        @(negedge clk);
        rst = 1'b0; en = 1'b1; dir = 1'b1; mode = 2'b00;
        expQ.push_back(ev(5, 0, 0));
        expQ.push_back(ev(8, 0, 0));
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            advance();
            gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
            if (gotV !== expV) begin
                nFail++;
                $display("FAIL reset_count[%0d]: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                         i, gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
            end
        end
        #3 rst = 1'b1;
        expQ.push_back(ev(2, 0, 0));
        #2;
        gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
        if (gotV !== expV) begin
            nFail++;
            $display("FAIL reset_async: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                     gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
        end
        #1 rst = 1'b0;
        expQ.push_back(ev(5, 0, 0));
        advance();
        gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
        if (gotV !== expV) begin
            nFail++;
            $display("FAIL reset_resume: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                     gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
        end
    endtask

    task automatic test_wrap_up();
        clr = 1'b1;
        expQ.push_back(ev(2, 0, 0));
        advance();
        clr = 1'b0; en = 1'b1; dir = 1'b1; mode = 2'b00;
        gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
        if (gotV !== expV) begin
            nFail++;
            $display("FAIL wrap_up_clr: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                     gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
        end
        expQ.push_back(ev(5, 0, 0));
        expQ.push_back(ev(8, 0, 0));
        expQ.push_back(ev(11, 0, 0));
        expQ.push_back(ev(2, 1, 0));
        expQ.push_back(ev(5, 0, 0));
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            advance();
            gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
            if (gotV !== expV) begin
                nFail++;
                $display("FAIL wrap_up[%0d]: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                         i, gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
            end
        end
    endtask

    task automatic test_wrap_down();
        load = 1'b1; loadval = 4'd4; mode = 2'b00;
        expQ.push_back(ev(4, 0, 0));
        advance();
        load = 1'b0; dir = 1'b0;
        expQ.push_back(ev(12, 1, 0));
        expQ.push_back(ev(9, 0, 0));
        expQ.push_back(ev(6, 0, 0));
        expQ.push_back(ev(3, 0, 0));
        expQ.push_back(ev(12, 1, 0));
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) advance();
            gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
            if (gotV !== expV) begin
                nFail++;
                $display("FAIL wrap_down[%0d]: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                         i, gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
            end
        end
    endtask

    task automatic test_saturate();
        load = 1'b1; loadval = 4'd8; mode = 2'b01; dir = 1'b1; en = 1'b1;
        expQ.push_back(ev(8, 0, 0));
        advance();
        load = 1'b0;
        expQ.push_back(ev(11, 0, 0));
        expQ.push_back(ev(12, 1, 0));
        expQ.push_back(ev(12, 0, 0));
        expQ.push_back(ev(12, 0, 0));
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) advance();
            gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
            if (gotV !== expV) begin
                nFail++;
                $display("FAIL saturate[%0d]: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                         i, gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
            end
        end
        dir = 1'b0;
        expQ.push_back(ev(9, 0, 0));
        advance();
        gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
        if (gotV !== expV) begin
            nFail++;
            $display("FAIL saturate_dir: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                     gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
        end
    endtask

    task automatic test_one_shot();
        load = 1'b1; loadval = 4'd8; mode = 2'b10; dir = 1'b1; en = 1'b1;
        expQ.push_back(ev(8, 0, 0));
        advance();
        load = 1'b0;
        expQ.push_back(ev(11, 0, 0));
        expQ.push_back(ev(12, 1, 1));
        for (int k = 0; k < 5; k++) expQ.push_back(ev(12, 0, 1));
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) advance();
            gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
            if (gotV !== expV) begin
                nFail++;
                $display("FAIL one_shot[%0d]: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                         i, gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
            end
        end
        #3 rst = 1'b1;
        expQ.push_back(ev(2, 0, 0));
        #2;
        gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
        if (gotV !== expV) begin
            nFail++;
            $display("FAIL one_shot_rst: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                     gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
        end
        #1 rst = 1'b0;
        load = 1'b1; loadval = 4'd5;
        expQ.push_back(ev(5, 0, 0));
        advance();
        load = 1'b0;
        gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
        if (gotV !== expV) begin
            nFail++;
            $display("FAIL one_shot_reload: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                     gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
        end
    endtask

    task automatic test_clamp_priority();
        logic [3:0] lvPat[5];
        logic       clrPat[5];
        logic       ldPat[5];
        logic       enPat[5];
        logic [1:0] mdPat[5];
        lvPat  = '{4'd15, 4'd0, 4'd9, 4'd11, 4'd11};
        clrPat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ldPat  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        enPat  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        mdPat  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
        dir = 1'b1;
        expQ.push_back(ev(12, 0, 0));
        expQ.push_back(ev(2, 0, 0));
        expQ.push_back(ev(2, 0, 0));
        expQ.push_back(ev(11, 0, 0));
        expQ.push_back(ev(2, 1, 0));
        for (int i = 0; i < 5; i++) begin
            loadval = lvPat[i]; clr = clrPat[i]; load = ldPat[i]; en = enPat[i]; mode = mdPat[i];
            advance();
            gotV = {tc, done, dataOut}; expV = expQ.pop_front(); nChecks++;
            if (gotV !== expV) begin
                nFail++;
                $display("FAIL clamp_priority[%0d]: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                         i, gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
            end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0; mode = 2'b00;
    endtask

    task automatic test_prescale();
        logic enPat[8];
        int   dPat[8];
        enPat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        dPat  = '{2, 2, 5, 5, 5, 5, 5, 8};
        en = 1'b0; en3 = 1'b0; mode = 2'b00; dir = 1'b1; clr = 1'b1;
        expQ.push_back(ev(2, 0, 0));
        advance();
        clr = 1'b0;
        gotV = {tc3, done3, dataOut3}; expV = expQ.pop_front(); nChecks++;
        if (gotV !== expV) begin
            nFail++;
            $display("FAIL prescale_clr: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                     gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
        end
        for (int k = 0; k < 8; k++) expQ.push_back(ev(dPat[k], 0, 0));
        for (int i = 0; i < 8; i++) begin
            en3 = enPat[i];
            advance();
            gotV = {tc3, done3, dataOut3}; expV = expQ.pop_front(); nChecks++;
            if (gotV !== expV) begin
                nFail++;
                $display("FAIL prescale[%0d]: dataOut=%0d tc=%b done=%b, expected dataOut=%0d tc=%b done=%b",
                         i, gotV[3:0], gotV[5], gotV[4], expV[3:0], expV[5], expV[4]);
            end
        end
        en3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_one_shot();
        test_clamp_priority();
        test_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
